// File: rtl/sr_ctrl_pkg.sv
// Shared encodings and the op-resolution helper for the SR bank sequencer.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10
  } state_e;

  // Command captured at the handshake; idx is kept beside it since its width is a parameter.
  typedef struct packed {
    op_e  op;
    logic id;
    logic qlat;
    logic oor;
  } cmd_t;

  // Value the addressed cell must hold once the command has been applied.
  function automatic logic expected_q(op_e op, logic q_now);
    case (op)
      OP_RESET:  return 1'b0;
      OP_SET:    return 1'b1;
      OP_TOGGLE: return ~q_now;
      default:   return q_now;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    if (advance) ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrates two command streams onto a bank of SR cells, pulses S/R for one cycle
// and verifies the readback, reporting completion and errors.
module sr_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [1:0]    req0_op,
  input  logic [IW-1:0] req0_idx,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [1:0]    req1_op,
  input  logic [IW-1:0] req1_idx,
  output logic          req1_ready,
  output logic [1:0]    done,
  output logic          err,
  output logic          err_sticky,
  output logic [N-1:0]  S,
  output logic [N-1:0]  R,
  input  logic [N-1:0]  Q
);

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  s_q, s_d, r_q, r_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;
  logic          err_sticky_q, err_sticky_d;

  logic [1:0]    grant;
  logic          advance;
  logic          acc_id, acc_q, acc_exp, acc_oor, acc_drive;
  op_e           acc_op;
  logic [IW-1:0] acc_idx;
  logic [N-1:0]  acc_sel, chk_sel;
  logic          chk_q, mism;

  // Grants only exist in IDLE and outside reset.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && rst}}),
    .advance (advance),
    .grant   (grant)
  );

  assign advance    = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign acc_id    = grant[1];
  assign acc_op    = op_e'(acc_id ? req1_op : req0_op);
  assign acc_idx   = acc_id ? req1_idx : req0_idx;
  assign acc_oor   = (32'(acc_idx) >= N);
  assign acc_sel   = N'(1) << acc_idx;
  assign acc_q     = |(Q & acc_sel);
  assign acc_exp   = expected_q(acc_op, acc_q);
  // Non-HOLD ops push the cell toward its expected value, so S and R are mutually exclusive.
  assign acc_drive = (acc_op != OP_HOLD) && !acc_oor;

  assign chk_sel = N'(1) << idx_q;
  assign chk_q   = |(Q & chk_sel);
  assign mism    = cmd_q.oor || (chk_q != expected_q(cmd_q.op, cmd_q.qlat));

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    s_d          = '0;
    r_d          = '0;
    done_d       = 2'b00;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          cmd_d.op   = acc_op;
          cmd_d.id   = acc_id;
          cmd_d.qlat = acc_q;
          cmd_d.oor  = acc_oor;
          idx_d      = acc_idx;
          state_d    = acc_oor ? ST_CHECK : ST_DRIVE;
          if (acc_drive && acc_exp)  s_d = acc_sel;
          if (acc_drive && !acc_exp) r_d = acc_sel;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        state_d      = ST_IDLE;
        done_d       = cmd_q.id ? 2'b10 : 2'b01;
        err_d        = mism;
        err_sticky_d = err_sticky_q | mism;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      idx_q        <= '0;
      s_q          <= '0;
      r_q          <= '0;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      s_q          <= s_d;
      r_q          <= r_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign S          = s_q;
  assign R          = r_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule
